// File: rtl/fp_mul_iter.sv
`default_nettype none
// ============================================================================
// Module   : fp_mul_iter
// Purpose  : Iterative (shift-add) floating-point multiplier with valid/ready
//            handshakes, parametrised exponent/fraction widths, flush-to-zero
//            on underflow and IEEE-754 style exception flags.
// Ports    : clk        - clock, rising edge
//            rst_n      - asynchronous active-low reset
//            in_valid   - operands present
//            in_ready   - block idle, operands accepted on in_valid&&in_ready
//            input_a/b  - operands {sign, exp, frac}
//            out_valid  - result present
//            out_ready  - consumer takes result on out_valid&&out_ready
//            output_z   - product
//            flags      - {invalid, overflow, underflow, inexact}
// Config   : FPU_RNE_EN defined   -> round-to-nearest-even
//            FPU_RNE_EN undefined -> truncate (round toward zero)
// Revision : 1.0 - initial release
// ============================================================================
module fp_mul_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] input_a,
  input  logic [EXP_W+MAN_W:0] input_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] output_z,
  output logic [3:0]           flags
);

  localparam int W  = EXP_W + MAN_W + 1;
  localparam int M  = MAN_W + 1;          // mantissa incl. hidden bit
  localparam int P  = 2 * M;              // full product width
  localparam int EW = EXP_W + 2;          // signed working exponent width
  localparam int CW = $clog2(M + 1);

  localparam logic [EW-1:0] BIAS     = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [EW-1:0] EXP_TOP  = EW'((1 << EXP_W) - 1);
  localparam logic [EW-1:0] EXP_ZERO = '0;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAN_W);
  localparam logic [W-1:0]  QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_MULT   = 3'd2,
    S_NORM   = 3'd3,
    S_ROUND  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic            sign_q, sign_d;
  logic [EW-1:0]   exp_q, exp_d;
  logic [P-1:0]    mcand_q, mcand_d;
  logic [M-1:0]    mier_q, mier_d;
  logic [P-1:0]    acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [M-1:0]    man_q, man_d;
  logic            guard_q, guard_d;
  logic            sticky_q, sticky_d;
  logic            spec_q, spec_d;
  logic [W-1:0]    z_q, z_d;
  logic [3:0]      flags_q, flags_d;

  // ---------------------------------------------------------------- decode
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_max, b_max, a_zero, b_zero;
  logic             a_nan, b_nan, a_inf, b_inf, a_snan, b_snan;
  logic             sign_ab;

  assign ea      = a_q[W-2:MAN_W];
  assign eb      = b_q[W-2:MAN_W];
  assign fa      = a_q[MAN_W-1:0];
  assign fb      = b_q[MAN_W-1:0];
  assign sign_ab = a_q[W-1] ^ b_q[W-1];
  assign a_max   = &ea;
  assign b_max   = &eb;
  assign a_zero  = (ea == '0);            // subnormals collapse to zero
  assign b_zero  = (eb == '0);
  assign a_nan   = a_max & (|fa);
  assign b_nan   = b_max & (|fb);
  assign a_inf   = a_max & ~(|fa);
  assign b_inf   = b_max & ~(|fb);
  assign a_snan  = a_nan & ~fa[MAN_W-1];
  assign b_snan  = b_nan & ~fb[MAN_W-1];

  logic         special;
  logic [W-1:0] spec_z;
  logic [3:0]   spec_f;

  always_comb begin
    special = 1'b1;
    spec_z  = '0;
    spec_f  = 4'b0000;
    if (a_nan || b_nan) begin
      spec_z = QNAN;
      spec_f = {a_snan | b_snan, 3'b000};
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      spec_z = QNAN;
      spec_f = 4'b1000;
    end else if (a_inf || b_inf) begin
      spec_z = {sign_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_zero || b_zero) begin
      spec_z = {sign_ab, {(W-1){1'b0}}};
    end else begin
      special = 1'b0;
    end
  end

  // ------------------------------------------------------- normalise/round
  // Left-justify the product so the hidden bit always sits at P-1.
  logic [P-1:0]     norm_sh;
  assign norm_sh = acc_q[P-1] ? acc_q : {acc_q[P-2:0], 1'b0};

  logic             rnd_up;
`ifdef FPU_RNE_EN
  assign rnd_up = guard_q & (sticky_q | man_q[0]);
`else
  assign rnd_up = 1'b0;
`endif

  logic [M:0]       sum_m;
  logic [MAN_W-1:0] frac_r;
  logic [EW-1:0]    exp_r;
  logic             inexact;

  assign sum_m   = {1'b0, man_q} + {{M{1'b0}}, rnd_up};
  // A carry out leaves 10..0 in sum_m; shifting right keeps a zero fraction.
  assign frac_r  = sum_m[M] ? sum_m[MAN_W:1] : sum_m[MAN_W-1:0];
  assign exp_r   = exp_q + {{(EW-1){1'b0}}, sum_m[M]};
  assign inexact = guard_q | sticky_q;

  // ------------------------------------------------------------------ FSM
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mcand_d  = mcand_q;
    mier_d   = mier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    man_d    = man_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    spec_d   = spec_q;
    z_d      = z_q;
    flags_d  = flags_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = input_a;
          b_d     = input_b;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        sign_d = sign_ab;
        if (special) begin
          // Special results are written in the first UNPACK cycle and
          // published on the second, giving specials a fixed 2-cycle latency.
          z_d     = spec_z;
          flags_d = spec_f;
          spec_d  = ~spec_q;
          if (spec_q) state_d = S_DONE;
        end else begin
          mcand_d = {{(P-M){1'b0}}, 1'b1, fa};
          mier_d  = {1'b1, fb};
          acc_d   = '0;
          cnt_d   = '0;
          exp_d   = {2'b00, ea} + {2'b00, eb} - BIAS;
          state_d = S_MULT;
        end
      end
      S_MULT: begin
        // Multiplier is consumed LSB first; multiplicand shifts up in step.
        if (mier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d = {mcand_q[P-2:0], 1'b0};
        mier_d  = {1'b0, mier_q[M-1:1]};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        man_d    = norm_sh[P-1:MAN_W+1];
        guard_d  = norm_sh[MAN_W];
        sticky_d = |norm_sh[MAN_W-1:0];
        exp_d    = exp_q + {{(EW-1){1'b0}}, acc_q[P-1]};
        state_d  = S_ROUND;
      end
      S_ROUND: begin
        if ($signed(exp_r) >= $signed(EXP_TOP)) begin
          z_d     = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags_d = 4'b0101;
        end else if ($signed(exp_r) <= $signed(EXP_ZERO)) begin
          z_d     = {sign_q, {(W-1){1'b0}}};
          flags_d = 4'b0011;
        end else begin
          z_d     = {sign_q, exp_r[EXP_W-1:0], frac_r};
          flags_d = {3'b000, inexact};
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mcand_q  <= '0;
      mier_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      man_q    <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      spec_q   <= 1'b0;
      z_q      <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mcand_q  <= mcand_d;
      mier_q   <= mier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      man_q    <= man_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      spec_q   <= spec_d;
      z_q      <= z_d;
      flags_q  <= flags_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign output_z  = z_q;
  assign flags     = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_mul_iter
// Purpose  : Self-checking bench for fp_mul_iter (single and half precision
//            instances) against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_mul_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, z;
  logic [3:0]  fl;
  logic        h_valid, h_ready, h_ovalid, h_oready;
  logic [15:0] ha, hb, hz;
  logic [3:0]  hfl;

  int n_vec = 0;
  int n_err = 0;

`ifdef FPU_RNE_EN
  localparam logic [31:0] Z_7P4_12P9 = 32'h42BEEB85;
`else
  localparam logic [31:0] Z_7P4_12P9 = 32'h42BEEB84;
`endif

  fp_mul_iter u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .input_a(a), .input_b(b), .out_valid(out_valid), .out_ready(out_ready),
    .output_z(z), .flags(fl)
  );

  fp_mul_iter #(.EXP_W(5), .MAN_W(10)) u_half (
    .clk(clk), .rst_n(rst_n), .in_valid(h_valid), .in_ready(h_ready),
    .input_a(ha), .input_b(hb), .out_valid(h_ovalid), .out_ready(h_oready),
    .output_z(hz), .flags(hfl)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: exact integer product, then normalise / round / classify.
  function automatic void ref_mul(input int ew, input int mw,
                                  input logic [31:0] op_a, input logic [31:0] op_b,
                                  output logic [31:0] rz, output logic [3:0] rf);
    longint emax, bias, ea, eb, fa, fb, sg, ma, mb, p, e, mant, rem, sh, qnan;
    bit g, st, nan_a, nan_b;
    emax  = (64'd1 << ew) - 1;
    bias  = (64'd1 << (ew - 1)) - 1;
    ea    = (longint'(op_a) >> mw) & emax;
    eb    = (longint'(op_b) >> mw) & emax;
    fa    = longint'(op_a) & ((64'd1 << mw) - 1);
    fb    = longint'(op_b) & ((64'd1 << mw) - 1);
    sg    = ((longint'(op_a) ^ longint'(op_b)) >> (ew + mw)) & 1;
    qnan  = (emax << mw) | (64'd1 << (mw - 1));
    nan_a = (ea == emax) && (fa != 0);
    nan_b = (eb == emax) && (fb != 0);
    rf = 4'b0000;
    rz = '0;
    if (nan_a || nan_b) begin
      rz    = 32'(qnan);
      rf[3] = (nan_a && (fa >> (mw - 1)) == 0) || (nan_b && (fb >> (mw - 1)) == 0);
    end else if ((ea == emax && eb == 0) || (eb == emax && ea == 0)) begin
      rz = 32'(qnan);
      rf = 4'b1000;
    end else if (ea == emax || eb == emax) begin
      rz = 32'((sg << (ew + mw)) | (emax << mw));
    end else if (ea == 0 || eb == 0) begin
      rz = 32'(sg << (ew + mw));
    end else begin
      ma = fa | (64'd1 << mw);
      mb = fb | (64'd1 << mw);
      p  = ma * mb;
      e  = ea + eb - bias;
      if (p >= (64'd1 << (2 * mw + 1))) begin
        sh = mw + 1;
        e  = e + 1;
      end else begin
        sh = mw;
      end
      mant = p >> sh;
      rem  = p & ((64'd1 << sh) - 1);
      g    = ((rem >> (sh - 1)) & 1) != 0;
      st   = (rem & ((64'd1 << (sh - 1)) - 1)) != 0;
`ifdef FPU_RNE_EN
      if (g && (st || (mant & 1) != 0)) mant = mant + 1;
      if (mant == (64'd1 << (mw + 1))) begin
        mant = mant >> 1;
        e    = e + 1;
      end
`endif
      if (e >= emax) begin
        rz = 32'((sg << (ew + mw)) | (emax << mw));
        rf = 4'b0101;
      end else if (e <= 0) begin
        rz = 32'(sg << (ew + mw));
        rf = 4'b0011;
      end else begin
        rz = 32'((sg << (ew + mw)) | (e << mw) | (mant & ((64'd1 << mw) - 1)));
        rf = {3'b000, g | st};
      end
    end
  endfunction

  task automatic do_op(input logic [31:0] op_a, input logic [31:0] op_b,
                       input bit has_k, input logic [31:0] k_z, input logic [3:0] k_f,
                       input int hold);
    logic [31:0] ez;
    logic [3:0]  ef;
    int          lat, n;
    logic [7:0]  xa, xb;
    ref_mul(8, 23, op_a, op_b, ez, ef);
    xa  = op_a[30:23];
    xb  = op_b[30:23];
    lat = (xa == 8'h00 || xa == 8'hFF || xb == 8'h00 || xb == 8'hFF) ? 2 : 27;
    @(negedge clk);
    chk("idle_ready", 32'(in_ready), 32'd1);
    a = op_a; b = op_b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("busy_ready", 32'(in_ready), 32'd0);
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), 32'(lat));
    chk("z", z, ez);
    chk("flags", 32'(fl), 32'(ef));
    if (has_k) begin
      chk("z_known", z, k_z);
      chk("flags_known", 32'(fl), 32'(k_f));
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0);
      a = $urandom; b = $urandom;
      @(posedge clk); #1;
      chk("hold_z", z, ez);
      chk("hold_flags", 32'(fl), 32'(ef));
      chk("hold_ready", 32'(in_ready), 32'd0);
      chk("hold_valid", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_valid", 32'(out_valid), 32'd0);
    chk("post_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic do_half(input logic [15:0] op_a, input logic [15:0] op_b,
                         input bit has_k, input logic [15:0] k_z);
    logic [31:0] ez;
    logic [3:0]  ef;
    int          lat, n;
    logic [4:0]  xa, xb;
    ref_mul(5, 10, {16'h0, op_a}, {16'h0, op_b}, ez, ef);
    xa  = op_a[14:10];
    xb  = op_b[14:10];
    lat = (xa == 5'h00 || xa == 5'h1F || xb == 5'h00 || xb == 5'h1F) ? 2 : 14;
    @(negedge clk);
    ha = op_a; hb = op_b; h_valid = 1'b1;
    @(posedge clk); #1;
    h_valid = 1'b0;
    n = 0;
    while (h_ovalid !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("h_latency", 32'(n), 32'(lat));
    chk("h_z", {16'h0, hz}, ez);
    chk("h_flags", 32'(hfl), 32'(ef));
    if (has_k) chk("h_z_known", {16'h0, hz}, {16'h0, k_z});
    // out_ready is held high, so out_valid lasts exactly one cycle.
    @(posedge clk); #1;
    chk("h_post_valid", 32'(h_ovalid), 32'd0);
    chk("h_post_ready", 32'(h_ready), 32'd1);
  endtask

  logic [31:0] spc [7] = '{32'h7F800000, 32'hFF800000, 32'h00000000, 32'h80000000,
                           32'h7FC00000, 32'h7F800001, 32'h00400000};
  logic [15:0] hspc [4] = '{16'h7C00, 16'h0000, 16'h7E00, 16'h7C01};

  function automatic logic [31:0] rnd_sp(input bit allow_special);
    logic [31:0] v;
    if (allow_special && $urandom_range(0, 9) > 6) v = spc[$urandom_range(0, 6)];
    else v = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
    return v;
  endfunction

  initial begin
    bit seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    h_valid = 1'b0; h_oready = 1'b1; ha = '0; hb = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_z", z, 32'd0);
    chk("rst_flags", 32'(fl), 32'd0);
    chk("rst_h_ready", 32'(h_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(32'h40000000, 32'h40400000, 1'b1, 32'h40C00000, 4'b0000, 0);
    do_op(32'h40ECCCCD, 32'h414E6666, 1'b1, Z_7P4_12P9,   4'b0001, 0);
    do_op(32'h7F800000, 32'h00000000, 1'b1, 32'h7FC00000, 4'b1000, 0);
    do_op(32'h7F800001, 32'h3F800000, 1'b1, 32'h7FC00000, 4'b1000, 0);
    do_op(32'h7FC00000, 32'h3F800000, 1'b1, 32'h7FC00000, 4'b0000, 0);
    do_op(32'h7F000000, 32'h7F000000, 1'b1, 32'h7F800000, 4'b0101, 0);
    do_op(32'h00800000, 32'h00800000, 1'b1, 32'h00000000, 4'b0011, 0);
    do_op(32'h80800000, 32'h00800000, 1'b1, 32'h80000000, 4'b0011, 0);
    do_op(32'hFF800000, 32'h40000000, 1'b1, 32'hFF800000, 4'b0000, 0);
    do_op(32'h00400000, 32'hC0400000, 1'b1, 32'h80000000, 4'b0000, 0);
    do_op(32'h3FFFFFFF, 32'h3FFFFFFF, 1'b0, 32'h0,        4'b0000, 10);

    // Reset during MULT aborts the operation.
    @(negedge clk);
    a = 32'h40000000; b = 32'h40400000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    chk("abort_no_result", 32'(seen), 32'd0);
    do_op(32'h40000000, 32'h40400000, 1'b1, 32'h40C00000, 4'b0000, 0);

    for (int i = 0; i < 30; i++) begin
      do_op(rnd_sp(1'b1), rnd_sp(1'b1), 1'b0, 32'h0, 4'b0000, $urandom_range(0, 2));
    end

    do_half(16'h4000, 16'h4200, 1'b1, 16'h4600);
    for (int i = 0; i < 10; i++) begin
      logic [15:0] x, y;
      x = {1'($urandom_range(0, 1)), 5'($urandom_range(1, 30)), 10'($urandom)};
      y = (i % 4 == 3) ? hspc[$urandom_range(0, 3)]
                       : {1'($urandom_range(0, 1)), 5'($urandom_range(1, 30)), 10'($urandom)};
      do_half(x, y, 1'b0, 16'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/fp_mul_iter.md
# fp_mul_iter

Parametrised, iterative floating-point multiplier with valid/ready handshakes on both sides. It is the next-generation multiply path of the FPU: exponent and fraction widths are generics, rounding is explicit, and IEEE-754 exception flags are reported. A shift-add datapath keeps area small. It sits behind the FPU operation decoder (sel = 01) and drives the shared result register.

## Interface
- EXP_W, 8: exponent field width; BIAS = 2^(EXP_W-1)-1.
- MAN_W, 23: stored fraction width. Word width W = EXP_W+MAN_W+1.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- in_valid  in  1  operands present.
- in_ready  out  1  block idle; operands accepted when in_valid && in_ready.
- input_a  in  W  operand A, {sign, exp, frac}.
- input_b  in  W  operand B.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes result when out_valid && out_ready.
- output_z  out  W  product.
- flags  out  4  {invalid, overflow, underflow, inexact}, valid with out_valid.

## Operation
- States: IDLE -> UNPACK -> MULT -> NORM -> ROUND -> DONE -> IDLE. UNPACK goes directly to DONE for special operands.
- IDLE: in_ready = 1. On accept, register operands.
- UNPACK:
  - sign = sa ^ sb.
  - Subnormal inputs (exp = 0) are treated as zero, with no flag.
  - Special cases, result written directly:
    - Any NaN input -> canonical qNaN (sign 0, exp all ones, fraction MSB 1, rest 0). invalid is set only if an input is signalling (fraction MSB 0).
    - inf × 0 -> qNaN, invalid.
    - inf × nonzero finite -> signed inf, no flags.
    - 0 × finite -> signed zero, no flags.
  - Otherwise, mantissas get the hidden 1 (MAN_W+1 bits), and exp = ea + eb - BIAS, computed in EXP_W+2 signed bits.
- MULT: MAN_W+1 cycles. Each cycle examines one multiplier bit, LSB first, and adds the shifted multiplicand into a 2(MAN_W+1)-bit accumulator. Counter from 0 to MAN_W.
- NORM: if product MSB is set, shift right 1 and exp += 1. Extract the MAN_W fraction bits, guard bit, and sticky bit (OR of the rest).
- ROUND: apply the rounding rule (see Configuration). If rounding carries out of the mantissa, shift and exp += 1.
  - exp ≥ 2^EXP_W - 1 -> signed inf, overflow + inexact.
  - exp ≤ 0 -> signed zero, underflow + inexact (flush-to-zero).
  - inexact = guard | sticky.
- DONE: out_valid = 1. output_z and flags are held stable until out_ready. On the handshake, go to IDLE. No accept is possible in the same cycle as a DONE handshake.

## Timing
- Reset values, applied asynchronously while rst_n = 0:
  - state = IDLE, so in_ready = 1.
  - out_valid = 0, output_z = 0, flags = 0.
  - Accumulator and counter = 0.
- Reset asserted mid-operation aborts the operation. No result is produced; the block is idle after release.
- Normal operand latency: out_valid rises on the (MAN_W+4)th rising edge after the accept edge. This is 27 edges at the defaults.
- Special operand latency: out_valid rises on the 2nd edge after accept.
- in_ready is 0 from the accept edge until the edge after the out handshake.
- out_valid with out_ready held high: one cycle of out_valid. in_ready = 1 the following cycle.
- out_ready may be high before out_valid; it has no effect until DONE.

## Configuration
- FPU_RNE_EN defined: round-to-nearest-even. Round up if guard && (sticky || LSB).
- FPU_RNE_EN undefined: truncate (round toward zero). No increment is ever applied. inexact and all other flags behave identically.
- Latency is the same in both builds.

## Test plan
- 2.0 × 3.0 (0x40000000, 0x40400000), defaults -> output_z 0x40C00000, flags 0000, out_valid 27 edges after accept.
- 7.4 × 12.9 (0x40ECCCCD, 0x414E6666) -> 0x42BEEB85 with FPU_RNE_EN, 0x42BEEB84 without. inexact set in both.
- 0x7F800000 × 0x00000000 -> 0x7FC00000, invalid. out_valid 2 edges after accept. Also 0x7F800001 × 1.0 -> 0x7FC00000 with invalid, and 0x7FC00000 × 1.0 -> 0x7FC00000 with no invalid.
- 0x7F000000 × 0x7F000000 -> 0x7F800000, overflow + inexact. 0x00800000 × 0x00800000 -> 0x00000000, underflow + inexact. 0x80800000 × 0x00800000 -> 0x80000000.
- Backpressure: out_ready held low 10 cycles after out_valid. output_z and flags stay constant and in_ready stays 0. in_valid pulses during that window are ignored.
- Reset mid-operation: rst_n low for 1 cycle during MULT -> out_valid stays 0 and in_ready returns to 1. The next operation, 2.0 × 3.0, yields 0x40C00000.
- EXP_W = 5, MAN_W = 10 (half precision): 0x4000 × 0x4200 -> 0x4600 after 14 edges.
